// File: rtl/framebuf_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads own the port,
// writer pixels are queued and retired on cycles with no read.
module framebuf_port_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 12,
    parameter int FIFO_DEPTH   = 8,
    parameter int FRAME_PIXELS = 76800
) (
    input  logic                          clk25,
    input  logic                          reset,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    input  logic                          wr_valid,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_din,
    input  logic [DATA_W-1:0]             mem_dout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          addr_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  LP_DEPTH = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LP_LIMIT = ADDR_W'(FRAME_PIXELS);

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_rd_s1;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_addr_err;

    logic w_grant_rd;
    logic w_grant_wr;
    logic w_ready;
    logic w_push;
    logic w_addr_ok;
    logic w_store;

    // Reads always win; the FIFO only drains on read-free cycles.
    assign w_grant_rd = !reset && rd_req;
    assign w_grant_wr = !reset && !rd_req && (r_count != '0);

    assign w_ready   = !reset && (r_count < LP_DEPTH);
    assign w_push    = wr_valid && w_ready;
    assign w_addr_ok = (wr_addr < LP_LIMIT);
    assign w_store   = w_push && w_addr_ok;

    always_ff @(posedge clk25) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_grant_wr) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_store, w_grant_wr})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk25) begin
        if (w_store) begin
            r_fifo_addr[r_wr_ptr] <= wr_addr;
            r_fifo_data[r_wr_ptr] <= wr_data;
        end
    end

    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (w_grant_rd) begin
            mem_en   = 1'b1;
            mem_addr = rd_addr;
        end else if (w_grant_wr) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = r_fifo_addr[r_rd_ptr];
            mem_din  = r_fifo_data[r_rd_ptr];
        end
    end

    // Stage 1 covers the BRAM's own read register; stage 2 captures dout.
    always_ff @(posedge clk25) begin
        if (reset) begin
            r_rd_s1    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_s1    <= w_grant_rd;
            r_rd_valid <= r_rd_s1;
            if (r_rd_s1) begin
                r_rd_data <= mem_dout;
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            r_addr_err <= 1'b0;
        end else if (w_push && !w_addr_ok) begin
            r_addr_err <= 1'b1;
        end
    end

    assign wr_ready   = w_ready;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;
    assign fifo_count = r_count;
    assign addr_err   = r_addr_err;

endmodule
